udp_tx_packer: RTL

UDP_TX_PACKER -- requirements
Module: udp_tx_packer

---
 rtl/udp_tx_packer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_packer.sv
// Byte-stream to UDP payload packer: packs bytes into 32-bit words, queues packet lengths and feeds a
// request-driven UDP transmitter. Define UDP_PACKER_TIMEOUT_EN to close idle partial packets.
module udp_tx_packer #(
  parameter int PKT_BYTES    = 1024,
  parameter int FIFO_WORDS   = 512,
  parameter int FLUSH_CYCLES = 125000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  input  logic        tx_req,
  output logic [31:0] tx_data,
  input  logic        tx_done,
  output logic        busy
);

  localparam int AW = $clog2(FIFO_WORDS);
  localparam logic [15:0] PKT_LAST   = 16'(PKT_BYTES - 1);
  localparam logic [AW:0] FILL_LIMIT = (AW+1)'(FIFO_WORDS - 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_SEND, S_GAP} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [FIFO_WORDS];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [31:0]   fifo_head;
  logic [15:0]   lq_mem [4];
  logic [1:0]    lq_wr, lq_rd;
  logic [2:0]    lq_cnt;
  logic [15:0]   lq_head;
  logic [31:0]   pack_reg, word_next, push_data;
  logic [1:0]    byte_idx;
  logic [15:0]   pkt_cnt, len_data;
  logic          run_q, space_ok, accept, close_byte, timeout_close;
  logic          push_word, push_len, fifo_pop, lq_pop, data_load, data_zero;
  logic [15:0]   words_left;
  logic [1:0]    gap_cnt;

  // in_ready stays low until the first clock after reset release
  assign space_ok   = (fifo_cnt <= FILL_LIMIT) && (lq_cnt != 3'd4);
  assign in_ready   = run_q & space_ok;
  assign accept     = in_valid & in_ready;
  assign word_next  = pack_reg | ({in_data, 24'h000000} >> {byte_idx, 3'b000});
  assign close_byte = accept & (in_last | (pkt_cnt == PKT_LAST));
  assign push_word  = (accept & ((byte_idx == 2'd3) | close_byte)) |
                      (timeout_close & (byte_idx != 2'd0));
  assign push_data  = accept ? word_next : pack_reg;
  assign push_len   = close_byte | timeout_close;
  assign len_data   = close_byte ? pkt_cnt + 16'd1 : pkt_cnt;

`ifdef UDP_PACKER_TIMEOUT_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_CYCLES - 1);
  logic [IW-1:0] idle_cnt;

  assign timeout_close = (pkt_cnt != 16'd0) && !accept && (idle_cnt == IDLE_LAST) && run_q && space_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (accept || pkt_cnt == 16'd0) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_LAST) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_close = 1'b0;
`endif

  // Packing stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      pack_reg <= 32'd0;
      byte_idx <= 2'd0;
      pkt_cnt  <= 16'd0;
    end else begin
      run_q <= 1'b1;
      if (timeout_close || close_byte) begin
        pack_reg <= 32'd0;
        byte_idx <= 2'd0;
        pkt_cnt  <= 16'd0;
      end else if (accept) begin
        pack_reg <= (byte_idx == 2'd3) ? 32'd0 : word_next;
        byte_idx <= byte_idx + 2'd1;
        pkt_cnt  <= pkt_cnt + 16'd1;
      end
    end
  end

  // Word FIFO and length queue storage
  always_ff @(posedge clk) begin
    if (push_word) mem[wr_ptr] <= push_data;
    if (push_len)  lq_mem[lq_wr] <= len_data;
  end

  assign fifo_head = mem[rd_ptr];
  assign lq_head   = lq_mem[lq_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      lq_wr    <= 2'd0;
      lq_rd    <= 2'd0;
      lq_cnt   <= 3'd0;
    end else begin
      if (push_word) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_word, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push_len) lq_wr <= lq_wr + 2'd1;
      if (lq_pop)   lq_rd <= lq_rd + 2'd1;
      case ({push_len, lq_pop})
        2'b10:   lq_cnt <= lq_cnt + 3'd1;
        2'b01:   lq_cnt <= lq_cnt - 3'd1;
        default: lq_cnt <= lq_cnt;
      endcase
    end
  end

  // Sender FSM
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    lq_pop     = 1'b0;
    data_load  = 1'b0;
    data_zero  = 1'b0;
    case (state)
      S_IDLE: begin
        if (lq_cnt != 3'd0) begin
          lq_pop     = 1'b1;
          state_next = S_START;
        end
      end
      S_START: state_next = S_SEND;
      S_SEND: begin
        if (tx_req) begin
          if (words_left != 16'd0) begin
            fifo_pop  = 1'b1;
            data_load = 1'b1;
          end else begin
            data_zero = 1'b1;
          end
        end
        if (tx_done) state_next = S_GAP;
      end
      S_GAP: begin
        // words the transmitter never asked for are drained so the next packet starts aligned
        if (words_left != 16'd0) fifo_pop = 1'b1;
        if (gap_cnt == 2'd3 && words_left == 16'd0) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      words_left  <= 16'd0;
      tx_byte_num <= 16'd0;
      tx_data     <= 32'd0;
      gap_cnt     <= 2'd0;
    end else begin
      state <= state_next;
      if (lq_pop) begin
        tx_byte_num <= lq_head;
        words_left  <= {2'b00, lq_head[15:2]} + {15'd0, |lq_head[1:0]};
      end else if (fifo_pop) begin
        words_left <= words_left - 16'd1;
      end
      if (data_load)      tx_data <= fifo_head;
      else if (data_zero) tx_data <= 32'd0;
      if (state != S_GAP)      gap_cnt <= 2'd0;
      else if (gap_cnt != 2'd3) gap_cnt <= gap_cnt + 2'd1;
    end
  end

  assign tx_start_en = (state == S_START);
  assign busy        = (state != S_IDLE);

endmodule
